// File: rtl/lockable_regfile_pkg.sv
// Shared definitions for the lockable register bank: address map, unlock FSM
// encoding and STATUS field layout.
package lockable_regfile_pkg;

    localparam int ADDR_LOCK_CTRL = 32'd0;
    localparam int ADDR_KEY       = 32'd1;
    localparam int ADDR_STATUS    = 32'd2;
    localparam int ADDR_DATA_BASE = 32'd3;

    localparam int ERR_CNT_W         = 32'd8;
    localparam int STATE_W           = 32'd2;
    localparam int STATUS_ERR_LSB    = 32'd0;
    localparam int STATUS_STATE_LSB  = 32'd8;
    localparam int STATUS_STICKY_BIT = 32'd10;

    typedef enum logic [STATE_W-1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY_WAIT = 2'd1,
        ST_OPEN     = 2'd2
    } lock_state_t;

    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        if (cnt == {ERR_CNT_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + 8'd1;
        end
    endfunction

endpackage

// File: rtl/lockable_regfile_bank_fsm.sv
// Two-key unlock state machine with OPEN-state idle timeout and the sticky
// freeze bit that pins the bank in LOCKED until reset.
module lock_unlock_fsm
    import lockable_regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] KEY0         = 32'hC0DE_0001,
    parameter logic [DATA_WIDTH-1:0] KEY1         = 32'hC0DE_0002,
    parameter int                    OPEN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  key_hit,
    input  logic                  lock_ctrl_hit,
    input  logic [DATA_WIDTH-1:0] write_data,
    output lock_state_t           state,
    output logic                  lock_ctrl_we,
    output logic                  sticky
);

    localparam int              CNT_W     = $clog2(OPEN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(OPEN_TIMEOUT);

    lock_state_t      state_r;
    lock_state_t      state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             sticky_r;
    logic             sticky_s;
    logic             lock_ctrl_we_s;

    assign cnt_inc_s = cnt_r + CNT_W'(32'd1);

    // Next-state, timeout counter and sticky update
    always_comb begin
        state_s        = state_r;
        cnt_s          = {CNT_W{1'b0}};
        sticky_s       = sticky_r;
        lock_ctrl_we_s = 1'b0;
        if (sticky_r) begin
            state_s = ST_LOCKED;
        end else begin
            case (state_r)
                ST_LOCKED: begin
                    if (wr && key_hit && (write_data == KEY0)) begin
                        state_s = ST_KEY_WAIT;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                ST_KEY_WAIT: begin
                    if (wr) begin
                        if (key_hit && (write_data == KEY1)) begin
                            state_s = ST_OPEN;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end else begin
                        state_s = ST_KEY_WAIT;
                    end
                end
                ST_OPEN: begin
                    if (wr) begin
                        if (lock_ctrl_hit) begin
                            // The mask write itself closes the bank again.
                            lock_ctrl_we_s = 1'b1;
                            state_s        = ST_LOCKED;
                            sticky_s       = write_data[DATA_WIDTH-1];
                        end else begin
                            state_s = ST_OPEN;
                        end
                    end else if (cnt_inc_s == CNT_LIMIT) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s = ST_OPEN;
                        cnt_s   = cnt_inc_s;
                    end
                end
                default: begin
                    state_s = ST_LOCKED;
                end
            endcase
        end
    end

    // State, counter and sticky registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_LOCKED;
            cnt_r    <= {CNT_W{1'b0}};
            sticky_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            sticky_r <= sticky_s;
        end
    end

    assign state        = state_r;
    assign lock_ctrl_we = lock_ctrl_we_s;
    assign sticky       = sticky_r;

endmodule

// File: rtl/lockable_regfile_bank.sv
// Register bank with per-register write locks guarded by a two-key unlock
// sequence, on the chip_select/write_en/read_en bus.
module lockable_regfile_bank
    import lockable_regfile_pkg::*;
#(
    parameter int                  ADDR_WIDTH   = 8,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  NUM_REGS     = 8,
    parameter logic [31:0]         KEY0         = 32'hC0DE_0001,
    parameter logic [31:0]         KEY1         = 32'hC0DE_0002,
    parameter int                  OPEN_TIMEOUT = 64,
    parameter logic [NUM_REGS-1:0] RESET_LOCK   = {NUM_REGS{1'b0}}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           chip_select,
    input  logic                           write_en,
    input  logic                           read_en,
    input  logic [DATA_WIDTH-1:0]          write_data,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           data_valid,
    output logic                           wr_err,
    output logic                           lock_open,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam logic [ADDR_WIDTH-1:0] A_LOCK    = ADDR_WIDTH'(ADDR_LOCK_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_KEY     = ADDR_WIDTH'(ADDR_KEY);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(ADDR_STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_DATA_LO = ADDR_WIDTH'(ADDR_DATA_BASE);
    localparam logic [ADDR_WIDTH-1:0] A_NUM     = ADDR_WIDTH'(NUM_REGS);

    logic                  wr_s;
    logic                  rd_s;
    logic                  lock_hit_s;
    logic                  key_hit_s;
    logic                  status_hit_s;
    logic                  data_hit_s;
    logic [ADDR_WIDTH-1:0] data_off_s;
    logic [NUM_REGS-1:0]   data_sel_s;
    logic                  data_locked_s;
    logic                  wr_ok_s;
    logic                  wr_rej_s;
    logic [DATA_WIDTH-1:0] rd_mux_s;
    lock_state_t           state_s;
    logic                  lock_ctrl_we_s;
    logic                  sticky_s;

    logic [DATA_WIDTH-1:0] data_r [NUM_REGS];
    logic [NUM_REGS-1:0]   lock_r;
    logic [ERR_CNT_W-1:0]  err_cnt_r;
    logic [DATA_WIDTH-1:0] read_data_r;
    logic                  data_valid_r;
    logic                  wr_err_r;

    assign wr_s         = chip_select & write_en;
    assign rd_s         = chip_select & read_en;
    assign lock_hit_s   = (addr == A_LOCK);
    assign key_hit_s    = (addr == A_KEY);
    assign status_hit_s = (addr == A_STATUS);
    assign data_off_s   = addr - A_DATA_LO;
    assign data_hit_s   = (addr >= A_DATA_LO) && (data_off_s < A_NUM);

    lock_unlock_fsm #(
        .DATA_WIDTH   (DATA_WIDTH),
        .KEY0         (DATA_WIDTH'(KEY0)),
        .KEY1         (DATA_WIDTH'(KEY1)),
        .OPEN_TIMEOUT (OPEN_TIMEOUT)
    ) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .wr            (wr_s),
        .key_hit       (key_hit_s),
        .lock_ctrl_hit (lock_hit_s),
        .write_data    (write_data),
        .state         (state_s),
        .lock_ctrl_we  (lock_ctrl_we_s),
        .sticky        (sticky_s)
    );

    // One-hot data register select
    always_comb begin
        data_sel_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            data_sel_s[i] = data_hit_s && (data_off_s == ADDR_WIDTH'(i));
        end
    end

    assign data_locked_s = |(data_sel_s & lock_r);

    // Write acceptance per address class
    always_comb begin
        wr_ok_s = 1'b0;
        if (lock_hit_s) begin
            wr_ok_s = lock_ctrl_we_s;
        end else if (key_hit_s) begin
            wr_ok_s = !sticky_s;
        end else if (status_hit_s) begin
            wr_ok_s = 1'b1;
        end else if (data_hit_s) begin
            wr_ok_s = !data_locked_s;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    assign wr_rej_s = wr_s && !wr_ok_s;

    // Read mux over the current (pre-write) register contents
    always_comb begin
        rd_mux_s = {DATA_WIDTH{1'b0}};
        if (lock_hit_s) begin
            rd_mux_s[NUM_REGS-1:0]   = lock_r;
            rd_mux_s[DATA_WIDTH-1]   = sticky_s;
        end else if (status_hit_s) begin
            rd_mux_s[STATUS_ERR_LSB +: ERR_CNT_W] = err_cnt_r;
            rd_mux_s[STATUS_STATE_LSB +: STATE_W] = state_s;
            rd_mux_s[STATUS_STICKY_BIT]           = sticky_s;
        end else if (data_hit_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rd_mux_s = rd_mux_s | (data_r[i] & {DATA_WIDTH{data_sel_s[i]}});
            end
        end else begin
            rd_mux_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Data registers and lock mask
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_r[i] <= {DATA_WIDTH{1'b0}};
            end
            lock_r <= RESET_LOCK;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_s && data_sel_s[i] && !lock_r[i]) begin
                    data_r[i] <= write_data;
                end
            end
            if (lock_ctrl_we_s) begin
                lock_r <= write_data[NUM_REGS-1:0];
            end
        end
    end

    // Error counter, error pulse and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r    <= {ERR_CNT_W{1'b0}};
            wr_err_r     <= 1'b0;
            read_data_r  <= {DATA_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
        end else begin
            wr_err_r     <= wr_rej_s;
            data_valid_r <= rd_s;
            if (wr_rej_s) begin
                err_cnt_r <= err_sat_inc(err_cnt_r);
            end else if (wr_s && status_hit_s) begin
                err_cnt_r <= {ERR_CNT_W{1'b0}};
            end
            if (rd_s) begin
                read_data_r <= rd_mux_s;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = data_r[g];
    end

    assign read_data  = read_data_r;
    assign data_valid = data_valid_r;
    assign wr_err     = wr_err_r;
    assign lock_open  = (state_s == ST_OPEN);

endmodule

// File: doc/lockable_regfile_bank.md
Name: lockable_regfile_bank

Overview:
Parametrised register bank with a per-register write-lock and a two-key unlock state machine.
- Lock bits are themselves protected: the two-word key sequence must open the bank before the lock mask can change.
- The bank can be permanently frozen until reset.
- Sits on the custom chip_select/write_en/read_en bus alongside other generated register blocks. Data registers are also exported to the datapath.

Parameters:
ADDR_WIDTH, 8, bus word-address width
DATA_WIDTH, 32, register and bus data width (>= 16)
NUM_REGS, 8, number of lockable data registers (1..DATA_WIDTH-1; NUM_REGS+3 <= 2**ADDR_WIDTH)
KEY0, 32'hC0DE_0001, first unlock word (truncated to DATA_WIDTH)
KEY1, 32'hC0DE_0002, second unlock word
OPEN_TIMEOUT, 64, idle cycles before the OPEN state falls back to LOCKED (>= 1)
RESET_LOCK, {NUM_REGS{1'b0}}, reset value of the lock mask

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
addr  in  ADDR_WIDTH  word address
chip_select  in  1  block select
write_en  in  1  write strobe
read_en  in  1  read strobe
write_data  in  DATA_WIDTH  write data
read_data  out  DATA_WIDTH  registered read data
data_valid  out  1  one-cycle pulse, read_data valid
wr_err  out  1  one-cycle pulse, previous-cycle write rejected
lock_open  out  1  unlock FSM in OPEN
reg_out  out  NUM_REGS*DATA_WIDTH  data registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset: single clock `clk`; `rst` is synchronous and active-high. On reset:
  - all data regs = 0; lock mask = RESET_LOCK; sticky = 0; err_cnt = 0;
  - FSM = LOCKED; timeout counter = 0;
  - read_data = 0; data_valid = 0; wr_err = 0.
- Strobes: wr = chip_select & write_en; rd = chip_select & read_en.
- Address map:
  - 0 LOCK_CTRL: [NUM_REGS-1:0] lock mask, [DATA_WIDTH-1] sticky.
  - 1 KEY: write-only, reads 0.
  - 2 STATUS: [7:0] err_cnt, [9:8] FSM state, [10] sticky. Read-only; any write clears err_cnt.
  - 3+i DATA_i.
  - All other addresses are unmapped.
- Unlock FSM encoding: LOCKED=0, KEY_WAIT=1, OPEN=2.
  - LOCKED -> KEY_WAIT: write of KEY0 to KEY while sticky=0.
  - KEY_WAIT -> OPEN: next wr is a write of KEY1 to KEY. Any other wr returns the FSM to LOCKED. Idle cycles do not change state.
  - OPEN -> LOCKED, on either of:
    - a write to LOCK_CTRL, which is applied in that same cycle;
    - the timeout counter reaching OPEN_TIMEOUT. The counter increments on every cycle in OPEN without wr and clears on any wr.
  - While sticky=1 the FSM is held in LOCKED; key writes are rejected.
- Write acceptance:
  - LOCK_CTRL is accepted only in OPEN. Writing bit DATA_WIDTH-1 = 1 sets sticky; sticky is cleared only by rst.
  - DATA_i is accepted iff lock[i]=0.
  - KEY writes are always accepted, except when sticky=1.
  - STATUS writes are always accepted.
  - Unmapped writes are rejected.
  - Rejected write: no state change. wr_err=1 on the following cycle. err_cnt increments by 1, saturating at 8'hFF.
  - A wrong KEY value is not an error; it only drives the FSM.
- Read:
  - Latency 1: on rd at cycle N, read_data and data_valid=1 appear at cycle N+1.
  - read_data holds its value until the next rd; data_valid is a single-cycle pulse.
  - Unmapped or KEY address reads return 0.
- Simultaneous rd and wr to the same address: read returns the pre-write value.
- reg_out reflects data registers combinationally from the flops, so an update is visible the cycle after an accepted write.
- Reset mid-sequence: KEY_WAIT or OPEN returns to LOCKED, the key progress is lost, and the lock mask returns to RESET_LOCK.

Decomposition:
- Package lockable_regfile_pkg holds:
  - address localparams (ADDR_LOCK_CTRL, ADDR_KEY, ADDR_STATUS, ADDR_DATA_BASE);
  - the FSM state enum;
  - STATUS bit positions;
  - the err_cnt width (8).
- Sub-module lock_unlock_fsm covers the FSM, the timeout counter and the sticky bit. Its inputs are wr, the decoded key/lock_ctrl hits and write_data. Its outputs are state and lock_ctrl_we.

Test Plan:
- Reset with defaults, then read STATUS -> read_data=0 at N+1, data_valid pulses exactly once.
- Write 32'h1234_5678 to DATA_2 (addr 5), read addr 5 -> 32'h1234_5678; reg_out[95:64] matches.
- KEY0 then KEY1 to addr 1, then write 32'h0000_0004 to addr 0 -> lock_open high between the KEY1 write and the LOCK_CTRL write, then low. A subsequent write to addr 5 -> wr_err pulse, DATA_2 unchanged, err_cnt=1.
- KEY0, then a write to addr 3, then KEY1 -> FSM in LOCKED (STATUS[9:8]=0); a LOCK_CTRL write is rejected.
- Unlock, idle 64 cycles -> lock_open drops on the timeout cycle; unlock, write 32'h8000_0000 to addr 0 -> sticky=1, later KEY0/KEY1 rejected; after rst, sticky=0.
- 300 rejected writes to unmapped addr 8'hF0 -> err_cnt saturates at 8'hFF; a write to STATUS -> err_cnt=0.
